// File: rtl/instr_fetch_queue_pkg.sv
// Shared constants and types for the instruction fetch queue.
// The optional combinational bypass is enabled with the IFQ_BYPASS_EN macro.
package instr_fetch_queue_pkg;

  localparam int          XLEN      = 32;
  localparam int          IFQ_DEPTH = 4;
  localparam logic [31:0] IFQ_NOP   = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } ifq_entry_t;

endpackage

// File: rtl/instr_fetch_queue_mem.sv
// ifq_mem: DEPTH x 64-bit register array for the fetch queue.
// It has one synchronous write port and one asynchronous read port. Contents are never reset.
module ifq_mem
  import instr_fetch_queue_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [63:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [63:0]   rdata
);

  logic [63:0] mem_r [DEPTH];

  // write port; storage deliberately has no reset, the top masks it while empty
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction queue between fetch and execute: circular buffer of {pc, instr}, flushed on taken jumps.
// Defining IFQ_BYPASS_EN lets a push reach the head in the same cycle when the queue is empty.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          push_valid_i,
  input  logic [31:0]   push_pc_i,
  input  logic [31:0]   push_instr_i,
  output logic          push_ready_o,
  output logic          pop_valid_o,
  output logic [31:0]   pop_pc_o,
  output logic [31:0]   pop_instr_o,
  input  logic          pop_ready_i,
  output logic [AW:0]   count_o
);

  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  logic        empty_s;
  logic        full_s;
  logic        bypass_s;
  logic        push_s;
  logic        pop_s;
  logic        mem_we_s;
  logic        mem_re_s;
  ifq_entry_t  wr_entry_s;
  ifq_entry_t  rd_entry_s;
  logic [63:0] rdata_s;

  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
  assign count_o = wr_ptr_r - rd_ptr_r;

`ifdef IFQ_BYPASS_EN
  assign bypass_s = empty_s & pop_ready_i & push_valid_i & ~flush_i;
`else
  assign bypass_s = 1'b0;
`endif

  assign push_ready_o = ~full_s & ~flush_i;
  assign push_s       = push_valid_i & push_ready_o;
  assign pop_s        = pop_valid_o & pop_ready_i;
  // a bypassed entry is consumed directly, so neither pointer moves for it
  assign mem_we_s     = push_s & ~bypass_s;
  assign mem_re_s     = pop_s & ~bypass_s;

  assign wr_entry_s.pc    = push_pc_i;
  assign wr_entry_s.instr = push_instr_i;
  assign rd_entry_s       = ifq_entry_t'(rdata_s);

  ifq_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we_s),
    .waddr (wr_ptr_r[AW-1:0]),
    .wdata (wr_entry_s),
    .raddr (rd_ptr_r[AW-1:0]),
    .rdata (rdata_s)
  );

  // pointer update: flush wins over push and pop in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else if (flush_i) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (mem_we_s) begin
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (mem_re_s) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

  // head mux: bypassed push, stored head, or NOP when nothing is available
  always_comb begin
    pop_valid_o = 1'b0;
    pop_pc_o    = 32'h0000_0000;
    pop_instr_o = IFQ_NOP;
    if (bypass_s) begin
      pop_valid_o = 1'b1;
      pop_pc_o    = push_pc_i;
      pop_instr_o = push_instr_i;
    end else if (!empty_s) begin
      pop_valid_o = 1'b1;
      pop_pc_o    = rd_entry_s.pc;
      pop_instr_o = rd_entry_s.instr;
    end else begin
      pop_valid_o = 1'b0;
      pop_pc_o    = 32'h0000_0000;
      pop_instr_o = IFQ_NOP;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized and directed bench for instr_fetch_queue against a queue-based reference model.
module tb_instr_fetch_queue;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        flush_i;
  logic        push_valid_i;
  logic [31:0] push_pc_i;
  logic [31:0] push_instr_i;
  logic        push_ready_o;
  logic        pop_valid_o;
  logic [31:0] pop_pc_o;
  logic [31:0] pop_instr_o;
  logic        pop_ready_i;
  logic [2:0]  count_o;

  int n_tests;
  int n_fail;

  logic [31:0] m_pc[$];
  logic [31:0] m_instr[$];

  instr_fetch_queue #(.DEPTH(4), .AW(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush_i),
    .push_valid_i (push_valid_i),
    .push_pc_i    (push_pc_i),
    .push_instr_i (push_instr_i),
    .push_ready_o (push_ready_o),
    .pop_valid_o  (pop_valid_o),
    .pop_pc_o     (pop_pc_o),
    .pop_instr_o  (pop_instr_o),
    .pop_ready_i  (pop_ready_i),
    .count_o      (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_bypass();
`ifdef IFQ_BYPASS_EN
    return (m_pc.size() == 0) && pop_ready_i && push_valid_i && !flush_i;
`else
    return 1'b0;
`endif
  endfunction

  // one cycle: drive, compare outputs against the model, then advance the model at the edge
  task automatic step(input logic fl, input logic pv, input logic [31:0] pc,
                      input logic [31:0] ins, input logic pr);
    bit          byp;
    bit          exp_valid;
    bit          exp_pready;
    logic [31:0] exp_pc;
    logic [31:0] exp_ins;
    @(negedge clk);
    flush_i      = fl;
    push_valid_i = pv;
    push_pc_i    = pc;
    push_instr_i = ins;
    pop_ready_i  = pr;
    #1;
    byp        = model_bypass();
    exp_pready = (m_pc.size() < 4) && !fl;
    if (byp) begin
      exp_valid = 1'b1; exp_pc = pc; exp_ins = ins;
    end else if (m_pc.size() > 0) begin
      exp_valid = 1'b1; exp_pc = m_pc[0]; exp_ins = m_instr[0];
    end else begin
      exp_valid = 1'b0; exp_pc = 32'h0; exp_ins = NOP;
    end
    check("count", 64'(count_o), 64'(m_pc.size()));
    check("push_ready", 64'(push_ready_o), 64'(exp_pready));
    check("pop_valid", 64'(pop_valid_o), 64'(exp_valid));
    check("pop_pc", 64'(pop_pc_o), 64'(exp_pc));
    check("pop_instr", 64'(pop_instr_o), 64'(exp_ins));
    @(posedge clk);
    if (fl) begin
      m_pc.delete();
      m_instr.delete();
    end else if (!byp) begin
      if (pr && m_pc.size() > 0) begin
        void'(m_pc.pop_front());
        void'(m_instr.pop_front());
      end
      if (pv && exp_pready) begin
        m_pc.push_back(pc);
        m_instr.push_back(ins);
      end
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0; flush_i = 1'b0; push_valid_i = 1'b0;
    push_pc_i = 32'h0; push_instr_i = 32'h0; pop_ready_i = 1'b0;
    #12;
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_valid", 64'(pop_valid_o), 64'd0);
    check("rst_instr", 64'(pop_instr_o), 64'(NOP));
    check("rst_pc", 64'(pop_pc_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    // fill with pc 0,4,8,C while held, then drain in order
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'(i * 4), 32'hA000_0000 + 32'(i), 1'b0);
    step(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_0000, 1'b0);
    check("full_count", 64'(count_o), 64'd4);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    idle();
    check("drained_instr", 64'(pop_instr_o), 64'(NOP));

    // wrap: interleaved pushes and toggled pop_ready
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 32'h0000_1000 + 32'(i * 4), 32'($urandom), 1'(i % 2));
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

    // simultaneous push and pop at count 2
    step(1'b0, 1'b1, 32'h0000_0200, 32'h1111_0000, 1'b0);
    step(1'b0, 1'b1, 32'h0000_0204, 32'h1111_0004, 1'b0);
    step(1'b0, 1'b1, 32'h0000_0208, 32'h1111_0008, 1'b1);
    idle();
    check("simul_count", 64'(count_o), 64'd2);
    check("simul_head", 64'(pop_pc_o), 64'h204);

    // flush at count 3 with a push in the same cycle
    step(1'b0, 1'b1, 32'h0000_020C, 32'h1111_000C, 1'b0);
    step(1'b1, 1'b1, 32'h0000_0999, 32'h2222_0000, 1'b0);
    step(1'b0, 1'b1, 32'h0000_0100, 32'h3333_0000, 1'b0);
    idle();
    check("flush_target", 64'(pop_pc_o), 64'h100);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

    // empty push with pop_ready high (bypass case when enabled)
    step(1'b0, 1'b1, 32'h0000_0020, 32'h4444_0000, 1'b1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    idle();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) != 0),
           32'($urandom) & 32'hFFFF_FFFC, 32'($urandom), 1'($urandom_range(0, 2) != 0));
      if (i == 200) begin
        // asynchronous reset mid-traffic
        @(negedge clk);
        flush_i = 1'b0; push_valid_i = 1'b0; pop_ready_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_count", 64'(count_o), 64'd0);
        check("arst_valid", 64'(pop_valid_o), 64'd0);
        check("arst_instr", 64'(pop_instr_o), 64'(NOP));
        check("arst_pc", 64'(pop_pc_o), 64'd0);
        m_pc.delete();
        m_instr.delete();
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
